// File: rtl/trap_pkg.sv
// ---------------------------------------------------------------------------
// trap_pkg : shared types and constants for the trap/MRET sequencer
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ACT      = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } kind_e;

  localparam logic [4:0] IRQ_CODE_MEI = 5'd11;
  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc : fixed-priority machine interrupt encoder (MEI > MSI > MTI)
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module irq_prio_enc
  import trap_pkg::*;
(
  input  logic [31:0] int_pending_vec,
  output logic        any,
  output logic [4:0]  code
);

  // Only the three machine-level sources are serviced; other bits never trap.
  logic unused_bits;
  assign unused_bits = ^{int_pending_vec[31:12], int_pending_vec[10:8],
                         int_pending_vec[6:4],   int_pending_vec[2:0]};

  always_comb begin
    any  = 1'b0;
    code = '0;
    if (int_pending_vec[IRQ_CODE_MEI]) begin
      any  = 1'b1;
      code = IRQ_CODE_MEI;
    end else if (int_pending_vec[IRQ_CODE_MSI]) begin
      any  = 1'b1;
      code = IRQ_CODE_MSI;
    end else if (int_pending_vec[IRQ_CODE_MTI]) begin
      any  = 1'b1;
      code = IRQ_CODE_MTI;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl : sequences trap entry / MRET (drain, CSR strobe, PC redirect)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_next_pc,
  input  logic            wb_exc,
  input  logic [4:0]      wb_exc_cause,
  input  logic [XLEN-1:0] wb_exc_val,
  input  logic            wb_is_mret,
  input  logic [31:0]     int_pending_vec,
  input  logic            global_int_en,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            mem_busy,
  output logic            trap_en,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_val,
  output logic            is_mret,
  output logic            flush,
  output logic            hold_pipe,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            drain_err
);

  localparam int              CNT_W   = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DRAIN_TIMEOUT - 1);

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   val_q, val_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              irq_any;
  logic [4:0]        irq_code;
  logic              irq_take;
  logic              event_det;
  logic [XLEN-1:0]   vec_base;
  logic [XLEN-1:0]   vec_addr;

  irq_prio_enc u_irq_prio_enc (
    .int_pending_vec (int_pending_vec),
    .any             (irq_any),
    .code            (irq_code)
  );

  assign irq_take  = global_int_en & irq_any & ~wb_exc & ~wb_is_mret;
  assign event_det = ~reset & (state_q == ST_IDLE) & wb_valid
                   & (wb_exc | wb_is_mret | irq_take);

  assign vec_base = {mtvec[XLEN-1:2], 2'b00};
  assign vec_addr = vec_base + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    val_d          = val_q;
    cnt_d          = cnt_q;
    trap_en        = 1'b0;
    trap_pc        = '0;
    trap_cause     = '0;
    trap_val       = '0;
    is_mret        = 1'b0;
    flush          = event_det;
    hold_pipe      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    drain_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (event_det) begin
          if (wb_exc) begin
            kind_d  = KIND_TRAP;
            pc_d    = wb_pc;
            cause_d = {{(XLEN-5){1'b0}}, wb_exc_cause};
            val_d   = wb_exc_val;
          end else if (wb_is_mret) begin
            kind_d  = KIND_MRET;
            pc_d    = '0;
            cause_d = '0;
            val_d   = '0;
          end else begin
            // The retiring instruction commits, so execution resumes after it.
            kind_d  = KIND_TRAP;
            pc_d    = wb_next_pc;
            cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
            val_d   = '0;
          end
          state_d = mem_busy ? ST_DRAIN : ST_ACT;
        end
      end
      ST_DRAIN: begin
        flush     = 1'b1;
        hold_pipe = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (!mem_busy) begin
          state_d = ST_ACT;
        end else if (cnt_q == CNT_LIM) begin
          drain_err = 1'b1;
          state_d   = ST_ACT;
        end
      end
      ST_ACT: begin
        flush     = 1'b1;
        hold_pipe = 1'b1;
        cnt_d     = '0;
        if (kind_q == KIND_MRET) begin
          is_mret = 1'b1;
        end else begin
          trap_en    = 1'b1;
          trap_pc    = pc_q;
          trap_cause = cause_q;
          trap_val   = val_q;
        end
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush          = 1'b1;
        hold_pipe      = 1'b1;
        redirect_valid = 1'b1;
        if (kind_q == KIND_MRET) begin
          redirect_pc = mepc;
        end else if (cause_q[XLEN-1] && (mtvec[1:0] == MTVEC_MODE_VECTORED)) begin
          redirect_pc = vec_addr;
        end else begin
          redirect_pc = vec_base;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_TRAP;
      pc_q    <= '0;
      cause_q <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  // The pipeline is held while sequencing, so a new event here is an upstream bug.
  a_no_event_while_busy: assert property (@(posedge clk) disable iff (reset)
    (state_q != ST_IDLE) |-> !(wb_valid && (wb_exc || wb_is_mret)));

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl : directed + randomized self-checking bench for trap_ctrl
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trap_ctrl;

  localparam int TO  = 16;
  localparam int WIN = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_exc, wb_is_mret, global_int_en, mem_busy;
  logic [31:0] wb_pc, wb_next_pc, wb_exc_val, int_pending_vec, mtvec, mepc;
  logic [4:0]  wb_exc_cause;
  logic        trap_en, is_mret, flush, hold_pipe, redirect_valid, drain_err;
  logic [31:0] trap_pc, trap_cause, trap_val, redirect_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid, exc, mret, gie;
    logic [4:0]  ecause;
    logic [31:0] pc, npc, eval, vec, mtvec, mepc;
    int          busy;
  } stim_t;

  typedef struct {
    bit          take, mret;
    logic [31:0] pc, cause, val, rpc;
  } exp_t;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_next_pc(wb_next_pc), .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause),
    .wb_exc_val(wb_exc_val), .wb_is_mret(wb_is_mret),
    .int_pending_vec(int_pending_vec), .global_int_en(global_int_en),
    .mtvec(mtvec), .mepc(mepc), .mem_busy(mem_busy), .trap_en(trap_en),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_val(trap_val),
    .is_mret(is_mret), .flush(flush), .hold_pipe(hold_pipe),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_err(drain_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural outcome of one retirement, straight from the trap rules.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    int          code;
    logic [31:0] base;
    e    = '{take: 0, mret: 0, pc: 0, cause: 0, val: 0, rpc: 0};
    base = s.mtvec - (s.mtvec % 4);
    code = -1;
    if (!s.valid) return e;
    if (s.exc) begin
      e.take = 1; e.pc = s.pc; e.cause = 32'(s.ecause); e.val = s.eval; e.rpc = base;
    end else if (s.mret) begin
      e.take = 1; e.mret = 1; e.rpc = s.mepc;
    end else if (s.gie) begin
      if (s.vec[11])      code = 11;
      else if (s.vec[3])  code = 3;
      else if (s.vec[7])  code = 7;
      if (code >= 0) begin
        e.take  = 1;
        e.pc    = s.npc;
        e.cause = 32'h8000_0000 + 32'(code);
        e.val   = 0;
        e.rpc   = (s.mtvec % 4 == 1) ? base + 32'(4 * code) : base;
      end
    end
    return e;
  endfunction

  task automatic run_event(input stim_t s, input string tag);
    exp_t        e;
    int          act_c, n_trap, n_mret, n_red, n_err, c_trap, c_mret, c_red, c_err;
    bit          err_exp;
    logic [31:0] o_pc, o_cause, o_val, o_rpc;
    e       = model(s);
    act_c   = (s.busy == 0) ? 1 : (((s.busy < TO) ? s.busy : TO) + 1);
    err_exp = (s.busy > TO);
    n_trap = 0; n_mret = 0; n_red = 0; n_err = 0;
    c_trap = -1; c_mret = -1; c_red = -1; c_err = -1;
    o_pc = 0; o_cause = 0; o_val = 0; o_rpc = 0;
    mtvec = s.mtvec; mepc = s.mepc; int_pending_vec = s.vec; global_int_en = s.gie;
    wb_pc = s.pc; wb_next_pc = s.npc; wb_exc_val = s.eval; wb_exc_cause = s.ecause;
    for (int j = 0; j < WIN; j++) begin
      @(negedge clk);
      wb_valid   = (j == 0) ? s.valid : 1'b0;
      wb_exc     = (j == 0) ? s.exc   : 1'b0;
      wb_is_mret = (j == 0) ? s.mret  : 1'b0;
      mem_busy   = (j < s.busy);
      #1;
      if (j == 0) check({tag, ".flush_detect"}, 32'(flush), 32'(e.take));
      if (j == 1) check({tag, ".hold_after"}, 32'(hold_pipe), 32'(e.take));
      if (j == act_c + 2) check({tag, ".hold_idle"}, 32'(hold_pipe), 32'd0);
      if (trap_en) begin
        n_trap++; c_trap = j; o_pc = trap_pc; o_cause = trap_cause; o_val = trap_val;
      end
      if (is_mret)        begin n_mret++; c_mret = j; end
      if (redirect_valid) begin n_red++;  c_red  = j; o_rpc = redirect_pc; end
      if (drain_err)      begin n_err++;  c_err  = j; end
    end
    mem_busy = 1'b0;
    check({tag, ".trap_cnt"}, 32'(n_trap), 32'(e.take && !e.mret));
    check({tag, ".mret_cnt"}, 32'(n_mret), 32'(e.take && e.mret));
    check({tag, ".redir_cnt"}, 32'(n_red), 32'(e.take));
    check({tag, ".derr_cnt"}, 32'(n_err), 32'(e.take && err_exp));
    if (e.take) begin
      if (e.mret) begin
        check({tag, ".mret_cyc"}, 32'(c_mret), 32'(act_c));
      end else begin
        check({tag, ".trap_cyc"}, 32'(c_trap), 32'(act_c));
        check({tag, ".trap_pc"}, o_pc, e.pc);
        check({tag, ".trap_cause"}, o_cause, e.cause);
        check({tag, ".trap_val"}, o_val, e.val);
      end
      check({tag, ".redir_cyc"}, 32'(c_red), 32'(act_c + 1));
      check({tag, ".redir_pc"}, o_rpc, e.rpc);
      if (err_exp) check({tag, ".derr_cyc"}, 32'(c_err), 32'(act_c - 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".trap_en"}, 32'(trap_en), 32'd0);
    check({tag, ".is_mret"}, 32'(is_mret), 32'd0);
    check({tag, ".flush"}, 32'(flush), 32'd0);
    check({tag, ".hold"}, 32'(hold_pipe), 32'd0);
    check({tag, ".redir"}, 32'(redirect_valid), 32'd0);
    check({tag, ".derr"}, 32'(drain_err), 32'd0);
    check({tag, ".tvals"}, trap_pc | trap_cause | trap_val | redirect_pc, 32'd0);
  endtask

  stim_t s;
  int    busy_tab[11] = '{0, 0, 0, 1, 2, 3, 5, 15, 16, 17, 30};
  int    n_red_post;

  initial begin
    reset = 1'b1; wb_valid = 0; wb_exc = 0; wb_is_mret = 0; global_int_en = 0;
    mem_busy = 0; wb_pc = 0; wb_next_pc = 0; wb_exc_val = 0; wb_exc_cause = 0;
    int_pending_vec = 0; mtvec = 0; mepc = 0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    s = '{valid: 1, exc: 1, mret: 0, gie: 0, ecause: 5'd2, pc: 32'h100, npc: 32'h104,
          eval: 32'hdead_beef, vec: 0, mtvec: 32'h200, mepc: 0, busy: 0};
    run_event(s, "exc_basic");

    s = '{valid: 1, exc: 0, mret: 0, gie: 1, ecause: 0, pc: 32'h80, npc: 32'h84,
          eval: 0, vec: (32'h1 << 11) | (32'h1 << 7), mtvec: 32'h401, mepc: 0, busy: 0};
    run_event(s, "irq_vectored");

    s = '{valid: 1, exc: 0, mret: 1, gie: 1, ecause: 0, pc: 32'h500, npc: 32'h504,
          eval: 0, vec: 32'h80, mtvec: 32'h200, mepc: 32'h3000, busy: 0};
    run_event(s, "mret_basic");

    s = '{valid: 1, exc: 0, mret: 0, gie: 1, ecause: 0, pc: 32'h3000, npc: 32'h3004,
          eval: 0, vec: 32'h80, mtvec: 32'h201, mepc: 32'h3000, busy: 0};
    run_event(s, "irq_after_mret");

    s = '{valid: 1, exc: 1, mret: 0, gie: 0, ecause: 5'd5, pc: 32'h140, npc: 32'h144,
          eval: 32'h1234, vec: 0, mtvec: 32'h200, mepc: 0, busy: 5};
    run_event(s, "exc_drain5");

    s.busy = 1000;
    run_event(s, "exc_drain_stuck");
    s.busy = TO;
    run_event(s, "exc_drain_edge");

    s = '{valid: 1, exc: 1, mret: 1, gie: 1, ecause: 5'd11, pc: 32'h600, npc: 32'h604,
          eval: 32'h77, vec: 32'h800, mtvec: 32'hfffffffd, mepc: 32'h9000, busy: 0};
    run_event(s, "exc_and_mret");

    // Reset landing in ACT must cancel the redirect.
    @(negedge clk);
    wb_pc = 32'h700; wb_exc = 1; wb_exc_cause = 5'd4; wb_valid = 1; mem_busy = 0;
    @(negedge clk);
    wb_valid = 0; wb_exc = 0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_in_act");
    n_red_post = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (redirect_valid || trap_en) n_red_post++;
    end
    check("reset_in_act.no_redirect", 32'(n_red_post), 32'd0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r        = $urandom_range(0, 3);
      s.valid  = ($urandom_range(0, 9) != 0);
      s.exc    = (r == 0) || (r == 3);
      s.mret   = (r == 1) || (r == 3);
      s.gie    = ($urandom_range(0, 3) != 0);
      s.ecause = 5'($urandom);
      s.pc     = $urandom;
      s.npc    = $urandom;
      s.eval   = $urandom;
      s.vec    = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      s.mtvec  = $urandom;
      s.mepc   = $urandom;
      s.busy   = busy_tab[$urandom_range(0, 10)];
      run_event(s, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
